piso_shr_buf: RTL and testbench
===============================

PISO_SHR_BUF -- requirements
Module: piso_shr_buf

Interface
REQ-001 Parameter: bits, default 4, data width in bits; legal range 2..16.
REQ-002 Parameter: hold_cyc, default 2, number of buffer (hold) cycles after the last data bit; legal range 1..15.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 din  input  bits  parallel word to transmit; sampled only on an accepted load.
REQ-006 load  input  1  request to start a frame; sampled on the rising clk edge.
REQ-007 dout  output  1  serial data, LSB first, registered.
REQ-008 busy  output  1  high while a frame is in progress (SHIFT or HOLD), registered.
REQ-009 done  output  1  single-cycle pulse on completion of a frame, registered.

Function
REQ-010 The state machine SHALL have three states: IDLE, SHIFT and HOLD.
REQ-011 In IDLE, on an edge with load=1, the block SHALL capture din, drive dout<=din[0], set the bit counter to 0, set busy<=1 and enter SHIFT.
REQ-012 In IDLE with load=0, the block SHALL drive dout<=0 and busy<=0, and SHALL remain in IDLE.
REQ-013 In SHIFT, while the bit counter is below bits-1, each edge SHALL drive dout with the next more-significant bit and increment the counter.
REQ-014 In SHIFT, on the edge where the bit counter equals bits-1, the block SHALL enter HOLD with the hold counter at 0, and dout SHALL keep the MSB.
REQ-015 In HOLD, the block SHALL keep dout and the internal register unchanged and increment the hold counter on each edge.
REQ-016 When hold_cyc cycles have elapsed, the block SHALL leave HOLD, assert done for exactly one cycle and deassert busy.
REQ-017 Frame timing: if load is accepted at edge E0, data bit k SHALL be present on dout from E0+k to E0+k+1.
REQ-018 Frame timing: busy SHALL be high from E0 to E0+bits+hold_cyc.
REQ-019 Frame timing: done SHALL be high from E0+bits+hold_cyc for exactly one cycle.
REQ-020 A load asserted while busy=1 SHALL be ignored, except at the final HOLD edge.
REQ-021 A load asserted at the final HOLD edge SHALL be accepted: next state SHIFT, busy stays 1, dout<=new din[0], and done still pulses.
REQ-022 din changes after load is accepted SHALL NOT affect the frame in progress.
REQ-023 Each counter SHALL be sized with $clog2 of its maximum value and SHALL NOT wrap within a frame.

Reset
REQ-024 While rst=1, the block SHALL hold: state=IDLE, dout=0, busy=0, done=0, internal register=0 and counters=0; load SHALL be ignored.
REQ-025 A reset asserted mid-frame SHALL abort the frame immediately, asynchronously and without a done pulse.
REQ-026 After rst deasserts, the first edge with load=1 SHALL start a new frame normally.

Structure
REQ-027 The module SHALL be a single module with no sub-modules.
REQ-028 No shared package SHALL be used; state encodings SHALL be local constants, 2 bits wide.
REQ-029 All outputs SHALL be driven directly from flops, with no combinational path from load or din to any output.

Verification
REQ-030 Scenario: bits=4, hold_cyc=2, din=4'b1011, load pulsed once -> dout sequence 1,1,0,1,1,1, then 0; busy high for 6 cycles; done high in cycle 7 only.
REQ-031 Scenario: load held high continuously with din=4'b0110 -> frames run back-to-back; busy never drops; done pulses every 6 cycles; dout follows 0,1,1,0,0,0 repeating.
REQ-032 Scenario: load=1 during SHIFT and during the first HOLD cycle with a different din -> ignored; the original frame completes unchanged.
REQ-033 Scenario: rst asserted at bit 2 of a frame -> dout, busy and done go to 0 immediately; no done pulse; the next load after reset transmits correctly.
REQ-034 Scenario: bits=8, hold_cyc=1, din=8'hA5 -> dout 1,0,1,0,0,1,0,1,1; done occurs 9 cycles after load.

Source files
------------

// File: rtl/piso_shr_buf.sv
// Parallel-in / serial-out shifter: sends a word LSB first, then holds the MSB
// for a programmable number of buffer cycles before pulsing done.
module piso_shr_buf #(
    parameter int bits     = 4,
    parameter int hold_cyc = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [bits-1:0] din,
    input  logic            load,
    output logic            dout,
    output logic            busy,
    output logic            done
);

    // state  | meaning
    // IDLE   | no frame; dout/busy low, waiting for load
    // SHIFT  | data bits being driven onto dout, LSB first
    // HOLD   | MSB held on dout for hold_cyc cycles; final edge may start a new frame
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Counters only reach bits-1 and hold_cyc-1, so they never wrap inside a frame.
    localparam int CW = $clog2(bits);
    localparam int HW = (hold_cyc > 1) ? $clog2(hold_cyc) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(bits - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(hold_cyc - 1);

    state_t          state_q,    state_d;
    logic [bits-1:0] shr_q,      shr_d;
    logic [CW-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            dout_q,     dout_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shr_q      <= '0;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            dout_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shr_q      <= shr_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shr_d      = shr_q;
        bit_cnt_d  = bit_cnt_q;
        hold_cnt_d = hold_cnt_q;
        dout_d     = dout_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d    = ST_SHIFT;
                    shr_d      = din;
                    dout_d     = din[0];
                    bit_cnt_d  = '0;
                    hold_cnt_d = '0;
                    busy_d     = 1'b1;
                end else begin
                    dout_d = 1'b0;
                    busy_d = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end else begin
                    // Shift right so the next bit to send always sits at index 1.
                    shr_d     = shr_q >> 1;
                    dout_d    = shr_q[1];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end

            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    done_d = 1'b1;
                    if (load) begin
                        // Back-to-back frame: busy stays high across the boundary.
                        state_d    = ST_SHIFT;
                        shr_d      = din;
                        dout_d     = din[0];
                        bit_cnt_d  = '0;
                        hold_cnt_d = '0;
                        busy_d     = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        dout_d  = 1'b0;
                        busy_d  = 1'b0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                dout_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_piso_shr_buf.sv
// Bench for piso_shr_buf: two instances (4-bit/hold 2 and 8-bit/hold 1) checked
// every cycle against a frame-timing reference model.
module tb_piso_shr_buf;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din4;
    logic       load4;
    logic       dout4, busy4, done4;
    logic [7:0] din8;
    logic       load8;
    logic       dout8, busy8, done8;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          act;
        int          age;
        logic [15:0] word;
        logic        dout;
        logic        busy;
        logic        done;
    } mdl_t;

    mdl_t m4, m8;

    piso_shr_buf #(.bits(4), .hold_cyc(2)) u_dut4 (
        .clk(clk), .rst(rst), .din(din4), .load(load4),
        .dout(dout4), .busy(busy4), .done(done4)
    );

    piso_shr_buf #(.bits(8), .hold_cyc(1)) u_dut8 (
        .clk(clk), .rst(rst), .din(din8), .load(load8),
        .dout(dout8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    function automatic mdl_t mreset();
        mdl_t n;
        n.act  = 1'b0;
        n.age  = 0;
        n.word = '0;
        n.dout = 1'b0;
        n.busy = 1'b0;
        n.done = 1'b0;
        return n;
    endfunction

    // age = clock edges since the accepting edge; a frame spans B+H edges.
    function automatic mdl_t mstep(mdl_t m, int B, int H, logic ld, logic [15:0] d);
        mdl_t n;
        bit   last_edge;
        n = m;
        last_edge = m.act && (m.age == B + H - 1);
        n.done = 1'b0;
        if (m.act) begin
            n.age = m.age + 1;
            if (n.age == B + H) begin
                n.act  = 1'b0;
                n.done = 1'b1;
            end
        end
        if (ld && (!m.act || last_edge)) begin
            n.act  = 1'b1;
            n.age  = 0;
            n.word = d;
        end
        n.busy = n.act;
        n.dout = n.act ? n.word[(n.age < B) ? n.age : B - 1] : 1'b0;
        return n;
    endfunction

    task automatic check_all(input string tag);
        tests++;
        assert (dout4 === m4.dout) else begin
            fails++;
            $error("FAIL %s dout4 observed=%b expected=%b", tag, dout4, m4.dout);
        end
        tests++;
        assert (busy4 === m4.busy) else begin
            fails++;
            $error("FAIL %s busy4 observed=%b expected=%b", tag, busy4, m4.busy);
        end
        tests++;
        assert (done4 === m4.done) else begin
            fails++;
            $error("FAIL %s done4 observed=%b expected=%b", tag, done4, m4.done);
        end
        tests++;
        assert (dout8 === m8.dout) else begin
            fails++;
            $error("FAIL %s dout8 observed=%b expected=%b", tag, dout8, m8.dout);
        end
        tests++;
        assert (busy8 === m8.busy) else begin
            fails++;
            $error("FAIL %s busy8 observed=%b expected=%b", tag, busy8, m8.busy);
        end
        tests++;
        assert (done8 === m8.done) else begin
            fails++;
            $error("FAIL %s done8 observed=%b expected=%b", tag, done8, m8.done);
        end
    endtask

    // Called at a falling edge: drives inputs, advances one clock, checks at the next falling edge.
    task automatic cycle(input string tag, input logic l4, input logic [3:0] d4,
                         input logic l8, input logic [7:0] d8);
        load4 = l4;
        din4  = d4;
        load8 = l8;
        din8  = d8;
        @(posedge clk);
        if (rst) begin
            m4 = mreset();
            m8 = mreset();
        end else begin
            m4 = mstep(m4, 4, 2, l4, {12'b0, d4});
            m8 = mstep(m8, 8, 1, l8, {8'b0, d8});
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst   = 1'b1;
        load4 = 1'b0;
        din4  = '0;
        load8 = 1'b0;
        din8  = '0;
        m4    = mreset();
        m8    = mreset();
        @(negedge clk);
        check_all("reset");
        // load must be ignored while reset is held
        cycle("reset_load", 1'b1, 4'hF, 1'b1, 8'hFF);
        cycle("reset_load", 1'b1, 4'hF, 1'b1, 8'hFF);
        rst = 1'b0;

        // single frame 1011 and 8-bit A5 frame together
        cycle("single", 1'b1, 4'b1011, 1'b1, 8'hA5);
        for (int i = 0; i < 10; i++) cycle("single", 1'b0, 4'b0000, 1'b0, 8'h00);

        // load held high: back-to-back frames
        for (int i = 0; i < 20; i++) cycle("b2b", 1'b1, 4'b0110, 1'b1, 8'h3C);
        for (int i = 0; i < 10; i++) cycle("b2b_tail", 1'b0, 4'b0000, 1'b0, 8'h00);

        // loads during SHIFT and early HOLD are ignored
        cycle("ignore", 1'b1, 4'b1001, 1'b1, 8'h81);
        for (int i = 0; i < 5; i++) cycle("ignore", 1'b1, 4'b0110, 1'b0, 8'h7E);
        for (int i = 0; i < 6; i++) cycle("ignore", 1'b0, 4'b1111, 1'b0, 8'hFF);

        // asynchronous reset at bit 2
        cycle("abort", 1'b1, 4'b1111, 1'b1, 8'hFF);
        cycle("abort", 1'b0, 4'b0000, 1'b0, 8'h00);
        cycle("abort", 1'b0, 4'b0000, 1'b0, 8'h00);
        rst = 1'b1;
        #1;
        m4 = mreset();
        m8 = mreset();
        check_all("async_rst");
        cycle("abort_hold", 1'b1, 4'b1010, 1'b1, 8'h55);
        rst = 1'b0;
        cycle("after_rst", 1'b1, 4'b1101, 1'b1, 8'hC3);
        for (int i = 0; i < 10; i++) cycle("after_rst", 1'b0, 4'b0000, 1'b0, 8'h00);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle("random",
                  ($urandom_range(0, 3) == 0), 4'($urandom),
                  ($urandom_range(0, 3) == 0), 8'($urandom));
        end
        for (int i = 0; i < 12; i++) cycle("drain", 1'b0, 4'b0000, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
